// File: rtl/rob_commit_unit_pkg.sv
// Shared widths, tag encoding and entry layout for the reorder buffer.
package rob_commit_unit_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int idxWidth   = $clog2(ROB_DEPTH);
    localparam int countWidth = idxWidth + 1;
    localparam int tagWidth   = 5;
    localparam int dataWidth  = 32;
    localparam int addrWidth  = 32;
    localparam int regWidth   = 5;

    localparam logic [tagWidth-1:0]  emptyTag  = 5'b10000;
    localparam logic [addrWidth-1:0] emptyAddr = 32'h0000_0000;
    localparam logic [dataWidth-1:0] emptyData = 32'h0000_0000;

    typedef struct packed {
        logic                 busy;
        logic                 ready;
        logic                 is_store;
        logic [regWidth-1:0]  rd;
        logic [addrWidth-1:0] pc;
        logic [addrWidth-1:0] pred_pc;
        logic [dataWidth-1:0] data;
        logic [addrWidth-1:0] actual_next_pc;
    } rob_entry_t;

    localparam rob_entry_t emptyEntry = rob_entry_t'({$bits(rob_entry_t){1'b0}});

    function automatic logic tag_hits(input logic [tagWidth-1:0] tag,
                                      input logic [idxWidth-1:0] idx);
        return (~tag[tagWidth-1]) && (tag[idxWidth-1:0] == idx);
    endfunction

    function automatic logic [addrWidth-1:0] fall_through(input logic [addrWidth-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// Reorder-buffer entry storage: allocation, writeback tag matching, retire and flush clear.
module rob_entry_array
    import rob_commit_unit_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_issue_en,
    input  logic [idxWidth-1:0]  i_issue_idx,
    input  logic                 i_issue_store,
    input  logic [regWidth-1:0]  i_issue_rd,
    input  logic [addrWidth-1:0] i_issue_pc,
    input  logic [addrWidth-1:0] i_issue_pred_pc,
    input  logic                 i_wb_en,
    input  logic [tagWidth-1:0]  i_ex_tag,
    input  logic [dataWidth-1:0] i_ex_data,
    input  logic [addrWidth-1:0] i_ex_jump,
    input  logic [tagWidth-1:0]  i_lsb_tag,
    input  logic [dataWidth-1:0] i_lsb_data,
    input  logic                 i_retire_en,
    input  logic [idxWidth-1:0]  i_head_idx,
    output rob_entry_t           o_head_entry
);

    rob_entry_t r_entries [ROB_DEPTH];

    assign o_head_entry = r_entries[i_head_idx];

    // Per-entry update; EX beats LSB on the same tag, allocation is applied last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= emptyEntry;
            end
        end else if (i_en) begin
            if (i_clear) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_entries[i] <= emptyEntry;
                end
            end else begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (i_wb_en && r_entries[i].busy && tag_hits(i_ex_tag, idxWidth'(i))) begin
                        r_entries[i].ready          <= 1'b1;
                        r_entries[i].data           <= i_ex_data;
                        r_entries[i].actual_next_pc <= (i_ex_jump != emptyAddr) ? i_ex_jump
                                                       : fall_through(r_entries[i].pc);
                    end else if (i_wb_en && r_entries[i].busy && tag_hits(i_lsb_tag, idxWidth'(i))) begin
                        r_entries[i].ready          <= 1'b1;
                        r_entries[i].data           <= i_lsb_data;
                        r_entries[i].actual_next_pc <= fall_through(r_entries[i].pc);
                    end
                    if (i_retire_en && (i_head_idx == idxWidth'(i))) begin
                        r_entries[i].busy  <= 1'b0;
                        r_entries[i].ready <= 1'b0;
                    end
                    if (i_issue_en && (i_issue_idx == idxWidth'(i))) begin
                        r_entries[i] <= '{busy:           1'b1,
                                          ready:          1'b0,
                                          is_store:       i_issue_store,
                                          rd:             i_issue_rd,
                                          pc:             i_issue_pc,
                                          pred_pc:        i_issue_pred_pc,
                                          data:           emptyData,
                                          actual_next_pc: emptyAddr};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer top: in-order allocate, out-of-order completion, in-order retire
// with misprediction detection and full flush at commit.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid_in,
    input  logic [regWidth-1:0]  issue_rd_in,
    input  logic [addrWidth-1:0] issue_pc_in,
    input  logic [addrWidth-1:0] issue_pred_pc_in,
    input  logic                 issue_is_store_in,
    output logic [tagWidth-1:0]  issue_tag_out,
    output logic                 rob_full_out,
    input  logic [tagWidth-1:0]  wb_pos_in_rob,
    input  logic [dataWidth-1:0] wb_data,
    input  logic [addrWidth-1:0] pc_to_jump,
    input  logic [tagWidth-1:0]  lsb_wb_tag_in,
    input  logic [dataWidth-1:0] lsb_wb_data_in,
    output logic                 commit_valid_out,
    output logic [tagWidth-1:0]  commit_tag_out,
    output logic [regWidth-1:0]  commit_rd_out,
    output logic [dataWidth-1:0] commit_data_out,
    output logic                 commit_store_out,
    output logic                 flush_out,
    output logic [addrWidth-1:0] redirect_pc_out
);

    logic [idxWidth-1:0]   r_head;
    logic [idxWidth-1:0]   r_tail;
    logic [countWidth-1:0] r_count;
    logic                  r_commit_valid;
    logic [tagWidth-1:0]   r_commit_tag;
    logic [regWidth-1:0]   r_commit_rd;
    logic [dataWidth-1:0]  r_commit_data;
    logic                  r_commit_store;
    logic                  r_flush;
    logic [addrWidth-1:0]  r_redirect_pc;

    rob_entry_t            w_head_entry;
    logic                  w_full;
    logic                  w_commit;
    logic                  w_mispredict;
    logic                  w_issue;
    logic [idxWidth-1:0]   w_head_next;
    logic [idxWidth-1:0]   w_tail_next;
    logic [countWidth-1:0] w_count_next;

    assign w_full = (r_count == countWidth'(ROB_DEPTH));

    rob_entry_array u_entries (
        .i_clk           (clk_in),
        .i_rst_n         (rst_n_in),
        .i_en            (rdy_in),
        .i_clear         (w_mispredict),
        .i_issue_en      (w_issue),
        .i_issue_idx     (r_tail),
        .i_issue_store   (issue_is_store_in),
        .i_issue_rd      (issue_rd_in),
        .i_issue_pc      (issue_pc_in),
        .i_issue_pred_pc (issue_pred_pc_in),
        .i_wb_en         (~r_flush),
        .i_ex_tag        (wb_pos_in_rob),
        .i_ex_data       (wb_data),
        .i_ex_jump       (pc_to_jump),
        .i_lsb_tag       (lsb_wb_tag_in),
        .i_lsb_data      (lsb_wb_data_in),
        .i_retire_en     (w_commit),
        .i_head_idx      (r_head),
        .o_head_entry    (w_head_entry)
    );

    // Commit/issue decisions and pointer/occupancy next state; the cycle after a flush is dead.
    always_comb begin
        w_commit     = 1'b0;
        w_mispredict = 1'b0;
        w_issue      = 1'b0;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        if (rdy_in) begin
            w_commit     = w_head_entry.busy & w_head_entry.ready;
            w_mispredict = w_commit & (w_head_entry.actual_next_pc != w_head_entry.pred_pc);
            w_issue      = issue_valid_in & ~w_full & ~r_flush;
        end else begin
            w_commit = 1'b0;
        end
        if (w_mispredict) begin
            w_head_next  = {idxWidth{1'b0}};
            w_tail_next  = {idxWidth{1'b0}};
            w_count_next = {countWidth{1'b0}};
        end else begin
            if (w_commit) begin
                w_head_next = r_head + idxWidth'(1'b1);
            end else begin
                w_head_next = r_head;
            end
            if (w_issue) begin
                w_tail_next = r_tail + idxWidth'(1'b1);
            end else begin
                w_tail_next = r_tail;
            end
            case ({w_issue, w_commit})
                2'b10:   w_count_next = r_count + countWidth'(1'b1);
                2'b01:   w_count_next = r_count - countWidth'(1'b1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Pointer state and registered retire/flush buses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head         <= {idxWidth{1'b0}};
            r_tail         <= {idxWidth{1'b0}};
            r_count        <= {countWidth{1'b0}};
            r_commit_valid <= 1'b0;
            r_commit_tag   <= {tagWidth{1'b0}};
            r_commit_rd    <= {regWidth{1'b0}};
            r_commit_data  <= emptyData;
            r_commit_store <= 1'b0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= emptyAddr;
        end else if (!rdy_in) begin
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;
        end else begin
            r_head         <= w_head_next;
            r_tail         <= w_tail_next;
            r_count        <= w_count_next;
            r_commit_valid <= w_commit;
            r_flush        <= w_mispredict;
            if (w_commit) begin
                r_commit_tag   <= tagWidth'(r_head);
                r_commit_rd    <= w_head_entry.is_store ? {regWidth{1'b0}} : w_head_entry.rd;
                r_commit_data  <= w_head_entry.data;
                r_commit_store <= w_head_entry.is_store;
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_head_entry.actual_next_pc;
            end
        end
    end

    assign issue_tag_out    = tagWidth'(r_tail);
    assign rob_full_out     = w_full;
    assign commit_valid_out = r_commit_valid;
    assign commit_tag_out   = r_commit_tag;
    assign commit_rd_out    = r_commit_rd;
    assign commit_data_out  = r_commit_data;
    assign commit_store_out = r_commit_store;
    assign flush_out        = r_flush;
    assign redirect_pc_out  = r_redirect_pc;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: expected retirements are queued at issue and popped on commit.
module tb_rob_commit_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in;
    logic [31:0] issue_pc_in;
    logic [31:0] issue_pred_pc_in;
    logic        issue_is_store_in;
    logic [4:0]  issue_tag_out;
    logic        rob_full_out;
    logic [4:0]  wb_pos_in_rob;
    logic [31:0] wb_data;
    logic [31:0] pc_to_jump;
    logic [4:0]  lsb_wb_tag_in;
    logic [31:0] lsb_wb_data_in;
    logic        commit_valid_out;
    logic [4:0]  commit_tag_out;
    logic [4:0]  commit_rd_out;
    logic [31:0] commit_data_out;
    logic        commit_store_out;
    logic        flush_out;
    logic [31:0] redirect_pc_out;

    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        store;
        logic        flush;
        logic [31:0] redir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_tail = 0;

    rob_commit_unit dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .issue_valid_in    (issue_valid_in),
        .issue_rd_in       (issue_rd_in),
        .issue_pc_in       (issue_pc_in),
        .issue_pred_pc_in  (issue_pred_pc_in),
        .issue_is_store_in (issue_is_store_in),
        .issue_tag_out     (issue_tag_out),
        .rob_full_out      (rob_full_out),
        .wb_pos_in_rob     (wb_pos_in_rob),
        .wb_data           (wb_data),
        .pc_to_jump        (pc_to_jump),
        .lsb_wb_tag_in     (lsb_wb_tag_in),
        .lsb_wb_data_in    (lsb_wb_data_in),
        .commit_valid_out  (commit_valid_out),
        .commit_tag_out    (commit_tag_out),
        .commit_rd_out     (commit_rd_out),
        .commit_data_out   (commit_data_out),
        .commit_store_out  (commit_store_out),
        .flush_out         (flush_out),
        .redirect_pc_out   (redirect_pc_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid_in    = 1'b0;
        issue_rd_in       = 5'd0;
        issue_pc_in       = 32'd0;
        issue_pred_pc_in  = 32'd0;
        issue_is_store_in = 1'b0;
        wb_pos_in_rob     = 5'b10000;
        wb_data           = 32'd0;
        pc_to_jump        = 32'd0;
        lsb_wb_tag_in     = 5'b10000;
        lsb_wb_data_in    = 32'd0;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk_in);
        #1;
        if (commit_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 32'(commit_tag_out), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("commit_tag", 32'(commit_tag_out), 32'(e.tag));
                check("commit_rd", 32'(commit_rd_out), 32'(e.rd));
                check("commit_data", commit_data_out, e.data);
                check("commit_store", 32'(commit_store_out), 32'(e.store));
                check("commit_flush", 32'(flush_out), 32'(e.flush));
                if (e.flush) check("redirect_pc", redirect_pc_out, e.redir);
            end
        end else begin
            check("no_flush_without_commit", 32'(flush_out), 32'd0);
        end
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pred,
                            input logic st, input logic [31:0] d, input logic fl,
                            input logic [31:0] redir, input bit push);
        exp_t e;
        check("issue_tag", 32'(issue_tag_out), 32'(m_tail));
        issue_valid_in    = 1'b1;
        issue_rd_in       = rd;
        issue_pc_in       = pc;
        issue_pred_pc_in  = pred;
        issue_is_store_in = st;
        if (push) begin
            e.tag = 5'(m_tail);
            e.rd = st ? 5'd0 : rd;
            e.data = d;
            e.store = st;
            e.flush = fl;
            e.redir = redir;
            sb.push_back(e);
        end
        tick();
        idle();
        m_tail = (m_tail + 1) % 16;
    endtask

    task automatic ex_wb(input logic [4:0] tag, input logic [31:0] d, input logic [31:0] jump);
        wb_pos_in_rob = tag;
        wb_data       = d;
        pc_to_jump    = jump;
        tick();
        idle();
    endtask

    task automatic lsb_wb(input logic [4:0] tag, input logic [31:0] d);
        lsb_wb_tag_in  = tag;
        lsb_wb_data_in = d;
        tick();
        idle();
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        idle();
        rdy_in   = 1'b1;
        rst_n_in = 1'b0;
        repeat (2) tick();
        check("rst_commit_valid", 32'(commit_valid_out), 32'd0);
        check("rst_commit_tag", 32'(commit_tag_out), 32'd0);
        check("rst_commit_rd", 32'(commit_rd_out), 32'd0);
        check("rst_commit_data", commit_data_out, 32'd0);
        check("rst_flush", 32'(flush_out), 32'd0);
        check("rst_redirect", redirect_pc_out, 32'd0);
        check("rst_issue_tag", 32'(issue_tag_out), 32'd0);
        check("rst_full", 32'(rob_full_out), 32'd0);
        rst_n_in = 1'b1;
        tick();
        check("post_rst_issue_tag", 32'(issue_tag_out), 32'd0);

        // ADDI rd=5, EX result 0x2A
        do_issue(5'd5, 32'h0, 32'h4, 1'b0, 32'h2A, 1'b0, 32'h0, 1'b1);
        check("addi_tail_adv", 32'(issue_tag_out), 32'd1);
        ex_wb(5'd0, 32'h2A, 32'h0);
        check("addi_latency", 32'(commit_valid_out), 32'd0);
        tick();
        check("addi_commit_valid", 32'(commit_valid_out), 32'd1);
        check("addi_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        check("addi_pulse_ends", 32'(commit_valid_out), 32'd0);

        // Out-of-order completion, in-order retire; second is a store via LSB
        do_issue(5'd6, 32'h10, 32'h14, 1'b0, 32'h11, 1'b0, 32'h0, 1'b1);
        do_issue(5'd7, 32'h14, 32'h18, 1'b1, 32'h22, 1'b0, 32'h0, 1'b1);
        lsb_wb(5'd2, 32'h22);
        check("ooo_hold", 32'(commit_valid_out), 32'd0);
        ex_wb(5'd1, 32'h11, 32'h0);
        tick();
        check("ooo_first", 32'(commit_valid_out), 32'd1);
        tick();
        check("ooo_second", 32'(commit_valid_out), 32'd1);
        check("ooo_sb_empty", 32'(sb.size()), 32'd0);

        // Fill all 16 entries, starting at tag 3 and wrapping through 0
        for (int k = 0; k < 16; k++) begin
            do_issue(5'((k % 31) + 1), 32'h400 + 32'(4 * k), 32'h404 + 32'(4 * k), 1'b0,
                     32'h1000 + 32'(m_tail), 1'b0, 32'h0, 1'b1);
        end
        check("full_set", 32'(rob_full_out), 32'd1);
        issue_valid_in = 1'b1;
        issue_rd_in    = 5'd31;
        issue_pc_in    = 32'h900;
        tick();
        idle();
        check("full_issue_ignored", 32'(issue_tag_out), 32'(m_tail));
        check("full_still", 32'(rob_full_out), 32'd1);
        ex_wb(5'd3, 32'h1003, 32'h0);
        tick();
        check("full_cleared", 32'(rob_full_out), 32'd0);
        do_issue(5'd9, 32'h500, 32'h504, 1'b0, 32'h1003, 1'b0, 32'h0, 1'b1);
        for (int j = 0; j < 16; j++) begin
            ex_wb(5'((4 + j) % 16), 32'h1000 + 32'((4 + j) % 16), 32'h0);
        end
        drain(8);

        // BEQ mispredict at tag 4, younger entries must vanish
        do_issue(5'd0, 32'h100, 32'h104, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1);
        do_issue(5'd10, 32'h104, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_issue(5'd11, 32'h108, 32'h10C, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        ex_wb(5'd5, 32'h55, 32'h0);
        ex_wb(5'd4, 32'h0, 32'h120);
        tick();
        check("beq_flush_seen", 32'(sb.size()), 32'd0);
        m_tail = 0;
        check("flush_issue_tag", 32'(issue_tag_out), 32'd0);
        check("flush_full", 32'(rob_full_out), 32'd0);
        issue_valid_in = 1'b1;
        issue_rd_in    = 5'd12;
        wb_pos_in_rob  = 5'd6;
        tick();
        idle();
        check("flush_cycle_issue_ignored", 32'(issue_tag_out), 32'd0);
        repeat (3) tick();

        // JAL rd=1 with correctly predicted target
        do_issue(5'd1, 32'h200, 32'h240, 1'b0, 32'h204, 1'b0, 32'h0, 1'b1);
        ex_wb(5'd0, 32'h204, 32'h240);
        tick();
        check("jal_commit", 32'(commit_valid_out), 32'd1);

        // EX wins over LSB on the same tag; rdy_in low freezes retirement
        do_issue(5'd13, 32'h300, 32'h304, 1'b0, 32'h77, 1'b0, 32'h0, 1'b1);
        lsb_wb_tag_in  = 5'd1;
        lsb_wb_data_in = 32'hBAD;
        ex_wb(5'd1, 32'h77, 32'h0);
        rdy_in = 1'b0;
        tick();
        check("rdy_hold", 32'(commit_valid_out), 32'd0);
        tick();
        check("rdy_hold_sb", 32'(sb.size()), 32'd1);
        rdy_in = 1'b1;
        tick();
        check("rdy_release", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-operation
        do_issue(5'd14, 32'h600, 32'h604, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_tag", 32'(issue_tag_out), 32'd3);
        rst_n_in = 1'b0;
        #1;
        check("async_rst_tag", 32'(issue_tag_out), 32'd0);
        check("async_rst_valid", 32'(commit_valid_out), 32'd0);
        tick();
        rst_n_in = 1'b1;
        m_tail = 0;
        ex_wb(5'd2, 32'h99, 32'h0);
        repeat (2) tick();
        check("post_rst_tag", 32'(issue_tag_out), 32'd0);
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
